// File: rtl/nios_ram_arb_pkg.sv
// Shared types and constants for the two-requester on-chip RAM arbiter.
// Read-pipeline entries carry the id of the requester that owns the return.
package nios_ram_arb_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } rd_ent_t;
endpackage

// File: rtl/nios_ram_rd_pipe.sv
// Read-return pipeline: tracks accepted reads through the RAM latency,
// then registers RAM data into the owning requester's readdata port.
module nios_ram_rd_pipe
  import nios_ram_arb_pkg::*;
#(
  parameter int DATA_W     = nios_ram_arb_pkg::DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  id_t               push_id,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              m0_readdatavalid,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] m1_readdata
);

  rd_ent_t pipe_q [RD_LATENCY];
  rd_ent_t tail;
  logic    tail0;
  logic    tail1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++)
        pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: push, id: push_id};
      for (int i = 1; i < RD_LATENCY; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail  = pipe_q[RD_LATENCY-1];
  assign tail0 = tail.valid & ~tail.id;
  assign tail1 = tail.valid & tail.id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
    end else begin
      m0_readdatavalid <= tail0;
      m1_readdatavalid <= tail1;
      if (tail0) m0_readdata <= ram_readdata;
      if (tail1) m1_readdata <= ram_readdata;
    end
  end

endmodule

// File: rtl/nios_ram_arbiter.sv
// Round-robin arbiter sharing a single-port on-chip RAM between the CPU
// data master (m0) and a DMA/peripheral master (m1).
module nios_ram_arbiter
  import nios_ram_arb_pkg::*;
#(
  parameter int ADDR_W     = nios_ram_arb_pkg::ADDR_W,
  parameter int DATA_W     = nios_ram_arb_pkg::DATA_W,
  parameter int BE_W       = nios_ram_arb_pkg::BE_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic              ready;
  id_t               rr_last;
  logic              req0;
  logic              req1;
  logic              grant0;
  logic              grant1;
  logic              push;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (ready) begin
      unique case (1'b1)
        (req0 & req1):  begin
          grant0 = rr_last;
          grant1 = ~rr_last;
        end
        (req0 & ~req1): grant0 = 1'b1;
        (~req0 & req1): grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // Idle cycles keep the last address/data on the bus to limit toggling.
  always_comb begin
    ram_address    = addr_q;
    ram_byteenable = be_q;
    ram_writedata  = wdata_q;
    if (grant0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
    end else if (grant1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
    end
  end

  assign ram_chipselect = grant0 | grant1;
  assign ram_write      = (grant0 & m0_write) | (grant1 & m1_write);
  assign ram_clken      = ready;

  assign push = (grant0 & m0_read & ~m0_write)
              | (grant1 & m1_read & ~m1_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready   <= 1'b0;
      rr_last <= 1'b1;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      ready <= 1'b1;
      if (grant0 | grant1) begin
        rr_last <= grant1;
        addr_q  <= ram_address;
        be_q    <= ram_byteenable;
        wdata_q <= ram_writedata;
      end
    end
  end

  nios_ram_rd_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk              (clk),
    .reset_n          (reset_n),
    .push             (push),
    .push_id          (grant1),
    .ram_readdata     (ram_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_readdata      (m0_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_readdata      (m1_readdata)
  );

endmodule

// File: tb/tb_nios_ram_arbiter.sv
// Bench for nios_ram_arbiter: behavioural RAM plus a reference model of
// round-robin arbitration, memory contents and read-return timing.
module tb_nios_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;

  nios_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency, byte-enabled writes.
  logic [31:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b])
            ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  typedef struct {
    int          due;
    bit          id;
    logic [31:0] data;
  } exp_t;

  logic [31:0] ref_mem [1024];
  exp_t        expq [$];
  bit          m_last;
  bit          m_ready;
  int          cyc;
  int          tests;
  int          fails;
  logic [31:0] last_rd0, last_rd1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r0, input bit w0, input logic [9:0] a0,
                      input logic [3:0] be0, input logic [31:0] d0,
                      input bit r1, input bit w1, input logic [9:0] a1,
                      input logic [3:0] be1, input logic [31:0] d1);
    bit q0, q1, g0, g1, win, ev0, ev1;
    logic [31:0] ed;
    logic [9:0] wa;
    logic [3:0] wbe;
    logic [31:0] wd;
    bit ww, wr;
    m0_read = r0; m0_write = w0; m0_address = a0;
    m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1;
    m1_byteenable = be1; m1_writedata = d1;
    #1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    g0 = 0; g1 = 0; win = 0;
    if (m_ready && (q0 || q1)) begin
      win = (q0 && q1) ? !m_last : !q0;
      g0 = !win;
      g1 = win;
    end
    chk("wait0", 32'(m0_waitrequest), 32'(q0 & !g0));
    chk("wait1", 32'(m1_waitrequest), 32'(q1 & !g1));
    chk("cs", 32'(ram_chipselect), 32'(g0 | g1));
    chk("clken", 32'(ram_clken), 32'(m_ready));
    wa = win ? a1 : a0;
    wbe = win ? be1 : be0;
    wd = win ? d1 : d0;
    ww = win ? w1 : w0;
    wr = win ? r1 : r0;
    if (g0 || g1) begin
      chk("addr", 32'(ram_address), 32'(wa));
      chk("wr", 32'(ram_write), 32'(ww));
    end
    ev0 = 0; ev1 = 0; ed = '0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      ev0 = !expq[0].id;
      ev1 = expq[0].id;
      ed = expq[0].data;
      void'(expq.pop_front());
    end
    chk("rdv0", 32'(m0_readdatavalid), 32'(ev0));
    chk("rdv1", 32'(m1_readdatavalid), 32'(ev1));
    if (ev0) chk("rdata0", m0_readdata, ed);
    if (ev1) chk("rdata1", m1_readdata, ed);
    if (m0_readdatavalid) last_rd0 = m0_readdata;
    if (m1_readdatavalid) last_rd1 = m1_readdata;
    if (g0 || g1) begin
      if (ww) begin
        for (int b = 0; b < 4; b++)
          if (wbe[b]) ref_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
      end else if (wr) begin
        expq.push_back('{due: cyc + 2, id: win, data: ref_mem[wa]});
      end
      m_last = win;
    end
    m_ready = 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    m0_read = 1; m0_write = 0; m1_read = 1; m1_write = 0;
    #1;
    chk("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
    chk("rst_cs", 32'(ram_chipselect), 32'd0);
    chk("rst_wr", 32'(ram_write), 32'd0);
    chk("rst_clken", 32'(ram_clken), 32'd0);
    chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
    expq.delete();
    m_last = 1;
    m_ready = 0;
    @(negedge clk);
    cyc++;
    chk("rst_rdv_hold", 32'(m0_readdatavalid | m1_readdatavalid), 32'd0);
    reset_n = 1;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    last_rd0 = '0; last_rd1 = '0;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'(i) * 32'h0101_0101;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[5] = 32'h1234_5678;  ref_mem[5] = 32'h1234_5678;
    ram_mem[10'h3FF] = '0;       ref_mem[10'h3FF] = '0;
    @(negedge clk);
    do_reset();

    // first read after reset: stalled one cycle, then accepted
    step(1, 0, 10'h005, 4'hF, '0, 0, 0, '0, '0, '0);
    step(1, 0, 10'h005, 4'hF, '0, 0, 0, '0, '0, '0);
    idle();
    idle();
    chk("reset_read", last_rd0, 32'h1234_5678);

    // continuous contention
    for (int i = 0; i < 8; i++)
      step(1, 0, 10'h010, 4'hF, '0, 1, 0, 10'h020, 4'hF, '0);
    idle(); idle();

    // byte-enabled write then read-back
    step(0, 0, '0, '0, '0, 0, 1, 10'h3FF, 4'b0101, 32'hAABB_CCDD);
    step(0, 0, '0, '0, '0, 1, 0, 10'h3FF, 4'hF, '0);
    idle(); idle();
    chk("byte_write", last_rd1, 32'h00BB_00DD);

    // read-after-write on consecutive cycles
    step(0, 1, 10'h001, 4'hF, 32'hDEAD_BEEF, 0, 0, '0, '0, '0);
    step(1, 0, 10'h001, 4'hF, '0, 0, 0, '0, '0, '0);
    idle(); idle();
    chk("raw", last_rd0, 32'hDEAD_BEEF);

    // read+write together counts as a write only
    step(1, 1, 10'h002, 4'hF, 32'h0000_0055, 0, 0, '0, '0, '0);
    idle(); idle();
    step(1, 0, 10'h002, 4'hF, '0, 0, 0, '0, '0, '0);
    idle(); idle();
    chk("rw_both", last_rd0, 32'h0000_0055);

    // reset with reads in flight
    step(1, 0, 10'h010, 4'hF, '0, 1, 0, 10'h020, 4'hF, '0);
    step(1, 0, 10'h010, 4'hF, '0, 1, 0, 10'h020, 4'hF, '0);
    do_reset();
    idle();
    step(1, 0, 10'h030, 4'hF, '0, 1, 0, 10'h040, 4'hF, '0);
    idle(); idle(); idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [9:0] a0, a1;
      a0 = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      step(1'($urandom), 1'($urandom_range(0, 3) == 0), a0,
           4'($urandom), $urandom,
           1'($urandom), 1'($urandom_range(0, 3) == 0), a1,
           4'($urandom), $urandom);
    end
    idle(); idle(); idle();
    chk("drain", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
